uart_txq: RTL
=============

# uart_txq

Transmit queue sitting directly upstream of the `uart` transmitter in the 25 MHz domain. Logic writes bytes at any rate into a small FIFO; the block pops them one at a time and drives the UART's `tx_byte`/`tx_send` handshake, waiting on `tx_ready` between bytes. Replaces the single-register `txb`/`txs` echo path so bursts of received or generated bytes are not lost while the transmitter is busy.

## Interface
- `DEPTH_LOG2`, 4, FIFO depth is 2^DEPTH_LOG2 bytes (16 by default); legal range 2..8
- `clock25`  in  1  system clock, 25 MHz from `pll`
- `reset_n`  in  1  asynchronous, active-low reset
- `wr_byte`  in  8  byte to enqueue
- `wr_en`  in  1  enqueue strobe, one byte per cycle high
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes
- `empty`  out  1  FIFO holds 0 bytes
- `count`  out  DEPTH_LOG2+1  bytes currently stored (not counting the byte in flight)
- `overflow`  out  1  sticky: a write was attempted while full
- `tx_byte`  out  8  byte presented to `uart`
- `tx_send`  out  1  send request to `uart`
- `tx_ready`  in  1  from `uart`: high when current byte is done/accepted

## Operation
- Storage: 2^DEPTH_LOG2 x 8 RAM, read/write pointers DEPTH_LOG2 bits, wrap modulo depth; `count` tracked separately, so full and empty are unambiguous.
- Write: at an edge with `wr_en`=1 and `full`=0, store `wr_byte` at write pointer, pointer+1, count+1. With `full`=1 the byte is dropped, FIFO unchanged, `overflow` set to 1 (cleared only by reset).
- `full`/`empty` are evaluated from pre-edge `count`: a write while full is rejected even if a pop happens the same edge.
- Simultaneous write and pop when not full: count unchanged, both pointers advance.
- FSM states:
  - IDLE: `tx_send`=0; if `count`!=0 -> LOAD.
  - LOAD: `tx_byte` <= RAM[read pointer], read pointer+1, count-1 -> SEND.
  - SEND: `tx_send`=1, `tx_byte` stable; when `tx_ready`=1 sampled -> GAP.
  - GAP: `tx_send`=0 for exactly one cycle -> IDLE.
- `tx_byte` changes only in LOAD; never while `tx_send`=1.
- Reset (async, any state): pointers, count = 0; `empty`=1, `full`=0, `overflow`=0, `tx_send`=0, `tx_byte`=8'h00, FSM = IDLE. Queued and in-flight bytes are discarded; `tx_send` falls without waiting for the edge.

## Timing
- All outputs registered.
- Write accepted at edge N into empty queue, UART idle: `count`=1 after N; LOAD after N+1; `tx_send`=1 and valid `tx_byte` after N+2 (2-cycle latency).
- `tx_ready` seen high at edge M while in SEND: `tx_send`=0 after M; next byte's `tx_send` rises after M+3 (GAP, IDLE, LOAD), giving a minimum 3-cycle low gap between requests.
- Throughput bounded by UART; the queue adds 3 cycles per byte.
- `tx_ready` already high on entering SEND: SEND lasts one cycle (`tx_send` high one cycle).

## Configuration
- `UART_TXQ_CRLF_EN` defined: in LOAD, when the head byte is 8'h0A and the internal `cr_sent` flag is 0, present 8'h0D instead, do not pop, set `cr_sent`; the following LOAD pops 8'h0A and clears `cr_sent`. Each LF leaves as CR LF; `count` decrements only on the real pop. Reset clears `cr_sent`.
- Not defined: bytes pass unmodified; `cr_sent` logic absent.

## Test plan
- Reset release, no writes -> `empty`=1, `count`=0, `tx_send`=0, `tx_byte`=8'h00, `overflow`=0 indefinitely.
- Write 8'h42 with uart model asserting `tx_ready` 10 cycles after `tx_send` rises -> `tx_send` high 2 cycles after write edge, `tx_byte`=8'h42 throughout, falls cycle after `tx_ready`.
- Burst write 8'h00..8'h0F on consecutive cycles, then 8'h10 -> `full`=1 after 16th write minus any pops; 17th write with `full`=1 sets `overflow`=1; UART sees 0x00..0x0F in order, 0x10 absent unless it was accepted.
- Write while full and pop same edge -> write dropped, `count` drops by 1, `overflow`=1.
- Assert `reset_n`=0 while in SEND with 5 bytes queued -> `tx_send`=0 immediately, `count`=0, subsequent write of 8'h55 transmits only 8'h55.
- With `UART_TXQ_CRLF_EN`: write 8'h41, 8'h0A, 8'h42 -> UART receives 0x41, 0x0D, 0x0A, 0x42; `count` reaches 0 after 3 pops. Without macro -> 0x41, 0x0A, 0x42.

Source files
------------

// File: rtl/uart_txq.sv
// uart_txq: byte FIFO that feeds the uart transmitter through its tx_byte/tx_send/tx_ready handshake.
// Optional feature: define UART_TXQ_CRLF_EN to send each LF byte as CR LF.
module uart_txq #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clock25,
  input  logic                reset_n,
  input  logic [7:0]          wr_byte,
  input  logic                wr_en,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic [7:0]          tx_byte,
  output logic                tx_send,
  input  logic                tx_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_nextCount;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic [7:0]            r_txByte;
  logic [7:0]            w_nextTxByte;
  logic                  r_txSend;
  logic                  w_nextTxSend;
  logic [7:0]            w_head;
  logic                  w_wrAccept;
  logic                  w_pop;
`ifdef UART_TXQ_CRLF_EN
  logic                  r_crSent;
  logic                  w_nextCrSent;
`endif

  // Writes are judged on the pre-edge full flag, so a same-edge pop never rescues a write while full.
  assign w_head     = r_mem[r_rdPtr];
  assign w_wrAccept = wr_en && !r_full;

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextTxSend = 1'b0;
    w_nextTxByte = r_txByte;
    w_pop        = 1'b0;
`ifdef UART_TXQ_CRLF_EN
    w_nextCrSent = r_crSent;
`endif
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_nextState  = SEND;
        w_nextTxSend = 1'b1;
`ifdef UART_TXQ_CRLF_EN
        // A LF at the head is sent twice through LOAD: first as CR without popping, then for real.
        if ((w_head == 8'h0A) && !r_crSent) begin
          w_nextTxByte = 8'h0D;
          w_nextCrSent = 1'b1;
        end else begin
          w_nextTxByte = w_head;
          w_pop        = 1'b1;
          w_nextCrSent = 1'b0;
        end
`else
        w_nextTxByte = w_head;
        w_pop        = 1'b1;
`endif
      end
      SEND: begin
        if (tx_ready) begin
          w_nextState = GAP;
        end else begin
          w_nextTxSend = 1'b1;
        end
      end
      GAP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    w_nextCount = r_count;
    if (w_wrAccept && !w_pop) begin
      w_nextCount = r_count + 1'b1;
    end else if (!w_wrAccept && w_pop) begin
      w_nextCount = r_count - 1'b1;
    end
  end

  always_ff @(posedge clock25) begin
    if (w_wrAccept) begin
      r_mem[r_wrPtr] <= wr_byte;
    end
  end

  // full/empty are registered from the next count so every output comes straight from a flop.
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_txByte   <= 8'h00;
      r_txSend   <= 1'b0;
    end else begin
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      r_count  <= w_nextCount;
      r_full   <= (w_nextCount == FULL_COUNT);
      r_empty  <= (w_nextCount == '0);
      r_txByte <= w_nextTxByte;
      r_txSend <= w_nextTxSend;
    end
  end

`ifdef UART_TXQ_CRLF_EN
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_crSent <= 1'b0;
    end else begin
      r_crSent <= w_nextCrSent;
    end
  end
`endif

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_byte  = r_txByte;
  assign tx_send  = r_txSend;

endmodule
